board_rle_encoder: RTL and testbench
====================================

// Module: board_rle_encoder
// PURPOSE
//  Run-length encodes the Game of Life board for upload to the HPS ("Save board").
//  Consumes one frame of cell pixels in scan order (from the framebuffer ring tap).
//  Emits bytes in the exact format the board loader consumes:
//  bit7 = cell value; bits[6:0] = extra repeats, so one byte covers 1..128 cells.
//  Output bytes pass through a small FWFT FIFO to the HPS-side byte reader.
// PARAMETERS
//  FRAME_PIXELS  2073600  cells per frame (1920*1080); pixel counter width = $clog2(FRAME_PIXELS)
//  FIFO_DEPTH    16       output byte FIFO entries, power of two, >=2
// PORTS
//  HDMI_CLK    in   1   single clock; all logic rising-edge
//  RESET_N     in   1   asynchronous active-low reset
//  start       in   1   1-cycle pulse: begin encoding one frame; ignored while busy
//  busy        out  1   high from accepted start until done
//  done        out  1   1-cycle pulse when last byte of frame is popped
//  pix_valid   in   1   pixel handshake: pixel offered
//  pix_ready   out  1   pixel handshake: encoder accepts (transfer = valid & ready)
//  pix_in      in   1   cell value, 1 = alive
//  byte_valid  out  1   FIFO not empty
//  byte_ready  in   1   consumer pops head (pop = valid & ready)
//  byte_out    out  8   FIFO head, {value, repeat[6:0]}
//  byte_count  out  $clog2(FRAME_PIXELS+1)  bytes pushed this frame (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE; busy=0, done=0, pix_ready=0, byte_valid=0, byte_out=0, byte_count=0,
//   FIFO pointers cleared, run_val=0, run_len=0, pix_cnt=0. Reset mid-frame discards everything.
//  FSM: IDLE -start-> FIRST -pixel-> RUN -last pixel accepted-> DRAIN -FIFO empty-> IDLE (+done).
//   FIRST: first accepted pixel loads run_val=pix_in, run_len=0; no byte pushed.
//   RUN: accepted pixel p: if p==run_val && run_len<127 -> run_len++;
//     else push {run_val,run_len}, then run_val=p, run_len=0.
//   Last pixel (pix_cnt==FRAME_PIXELS-1), in FIRST or RUN: apply the rule above to it, then
//     push the resulting open run in the same cycle. Two pushes in one cycle are never needed
//     beyond this case; this case writes two entries when the last pixel breaks the run.
//  pix_ready = (FIRST|RUN) && free_slots>=2. This guarantees room for the double push on the
//   last pixel and makes the no-loss rule trivially hold.
//  Run boundary: run_len wraps at 127, so 128 equal cells -> 0xFF/0x7F, and cell 129 starts a new byte.
//  Latency: a byte pushed on accept cycle N is visible on byte_out at N+1 (registered write, FWFT read).
//  Simultaneous push and pop: both legal in the same cycle; occupancy changes by pushes-pops.
//  FIFO order strictly preserved. Pops in IDLE after a reset never occur (FIFO empty).
//  pix_cnt counts accepted pixels; pixels offered in IDLE/DRAIN are not accepted.
//  start arriving in the same cycle as done is ignored; assert start after done.
//  Decoded length check: sum over bytes of (repeat+1) == FRAME_PIXELS, always.
// CONFIGURATION
//  RLE_BYTECOUNT_EN defined: byte_count increments per pushed byte (+2 on double push),
//   clears on accepted start, and holds after done for software readback.
//  RLE_BYTECOUNT_EN undefined: byte_count tied to 0; no counter logic synthesized.
// TESTING
//  T1 FRAME_PIXELS=16, 16 zeros, byte_ready=1 -> single byte 0x0F, done 1 cycle after pop, busy=0.
//  T2 FRAME_PIXELS=256, all ones -> 0xFF,0xFF; 257-cell variant (FRAME=257) -> 0xFF,0xFF,0x80.
//  T3 FRAME_PIXELS=4, 1,0,1,0 -> 0x80,0x00,0x80,0x00 (last pixel double push), byte_count=4 w/ macro.
//  T4 FIFO_DEPTH=4, FRAME=8 alternating, byte_ready=0 -> pix_ready low once free<2, no byte lost;
//     release byte_ready -> 8 bytes 0x80,0x00,... in order, then done.
//  T5 RESET_N low mid-frame (pix_cnt=5, FIFO holding 2) -> byte_valid=0, busy=0 immediately;
//     new start with T1 stimulus -> exactly 0x0F.
//  T6 Random frames (FRAME=1000, random byte_ready) -> decoded expansion equals the input stream,
//     and the sum over bytes of (repeat+1) equals 1000.

Source files
------------

// File: rtl/board_rle_encoder.sv
// Run-length encoder for the Life board: one frame of cells in, {value, repeat[6:0]} bytes out via a FWFT FIFO.
// Optional per-frame byte counter is built only when RLE_BYTECOUNT_EN is defined.
module board_rle_encoder #(
  parameter int FRAME_PIXELS = 2073600,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                              HDMI_CLK,
  input  logic                              RESET_N,
  input  logic                              start,
  output logic                              busy,
  output logic                              done,
  input  logic                              pix_valid,
  output logic                              pix_ready,
  input  logic                              pix_in,
  output logic                              byte_valid,
  input  logic                              byte_ready,
  output logic [7:0]                        byte_out,
  output logic [$clog2(FRAME_PIXELS+1)-1:0] byte_count
);
  localparam int PCW = (FRAME_PIXELS > 2) ? $clog2(FRAME_PIXELS) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, FIRST, RUN, DRAIN} state_t;
  state_t state, state_nx;

  logic           run_val, nval;
  logic [6:0]     run_len, nlen;
  logic [PCW-1:0] pix_cnt;
  logic [7:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count;
  logic           take, last, brk, push0, push1, pop;
  logic [7:0]     wdat0, wdat1;

  assign take       = pix_valid & pix_ready;
  assign last       = (pix_cnt == PCW'(FRAME_PIXELS - 1));
  assign pix_ready  = (state == FIRST || state == RUN) && (count <= (AW+1)'(FIFO_DEPTH - 2));
  assign busy       = (state != IDLE);
  assign byte_valid = (count != '0);
  assign pop        = byte_valid & byte_ready;
  assign byte_out   = byte_valid ? mem[rd_ptr] : 8'h00;

  // Run update; on the last pixel the open run is flushed as well (second slot if the pixel broke the run).
  always_comb begin
    push0 = 1'b0;
    push1 = 1'b0;
    brk   = 1'b0;
    wdat0 = {run_val, run_len};
    wdat1 = 8'h00;
    nval  = run_val;
    nlen  = run_len;
    if (take) begin
      if (state == FIRST) begin
        nval = pix_in;
        nlen = 7'd0;
      end else if (pix_in == run_val && run_len != 7'd127) begin
        nlen = run_len + 7'd1;
      end else begin
        brk   = 1'b1;
        push0 = 1'b1;
        nval  = pix_in;
        nlen  = 7'd0;
      end
      if (last) begin
        if (brk) begin
          push1 = 1'b1;
          wdat1 = {nval, nlen};
        end else begin
          push0 = 1'b1;
          wdat0 = {nval, nlen};
        end
      end
    end
  end

  always_comb begin
    state_nx = state;
    done     = 1'b0;
    case (state)
      IDLE:  if (start) state_nx = FIRST;
      FIRST: if (take) state_nx = last ? DRAIN : RUN;
      RUN:   if (take && last) state_nx = DRAIN;
      DRAIN: if (count == '0) begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge HDMI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state   <= IDLE;
      run_val <= 1'b0;
      run_len <= 7'd0;
      pix_cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && start) pix_cnt <= '0;
      else if (take) pix_cnt <= pix_cnt + PCW'(1);
      if (take) begin
        run_val <= nval;
        run_len <= nlen;
      end
    end
  end

  always_ff @(posedge HDMI_CLK) begin
    if (push0) mem[wr_ptr] <= wdat0;
    if (push1) mem[AW'(wr_ptr + AW'(1))] <= wdat1;
  end

  always_ff @(posedge HDMI_CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push0) + AW'(push1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + (AW+1)'(push0) + (AW+1)'(push1) - (AW+1)'(pop);
    end
  end

`ifdef RLE_BYTECOUNT_EN
  always_ff @(posedge HDMI_CLK or negedge RESET_N) begin
    if (!RESET_N) byte_count <= '0;
    else if (state == IDLE && start) byte_count <= '0;
    else byte_count <= byte_count + $bits(byte_count)'(push0) + $bits(byte_count)'(push1);
  end
`else
  assign byte_count = '0;
`endif

endmodule

// File: tb/tb_board_rle_encoder.sv
// Scoreboard bench for board_rle_encoder: directed frames queue expected bytes, a monitor pops and compares.
module tb_board_rle_encoder;
  localparam int FRAME = 130;
  localparam int DEPTH = 4;
  localparam int BCW   = $clog2(FRAME + 1);

  logic HDMI_CLK = 1'b0, RESET_N = 1'b0, start = 1'b0;
  logic pix_valid = 1'b0, pix_in = 1'b0, byte_ready = 1'b0;
  logic busy, done, pix_ready, byte_valid;
  logic [7:0] byte_out;
  logic [BCW-1:0] byte_count;

  board_rle_encoder #(.FRAME_PIXELS(FRAME), .FIFO_DEPTH(DEPTH)) dut (
    .HDMI_CLK(HDMI_CLK), .RESET_N(RESET_N), .start(start), .busy(busy), .done(done),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_in(pix_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_out(byte_out), .byte_count(byte_count)
  );

  always #5 HDMI_CLK = ~HDMI_CLK;

  int n_chk = 0, n_fail = 0;
  logic [7:0] exp_q[$];
  int rdy_mode = 1;
  int acc = 0;
  bit feeding = 0;
  int cyc = 0;
  int last_pop_cyc = -10;
  int dec_len = 0;
  logic [FRAME-1:0] fr;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(posedge HDMI_CLK) cyc <= cyc + 1;

  always @(posedge HDMI_CLK) begin
    #1;
    case (rdy_mode)
      0:       byte_ready = 1'b0;
      1:       byte_ready = 1'b1;
      default: byte_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Monitor: every pop is compared against the head of the expected queue.
  always @(negedge HDMI_CLK) begin
    if (RESET_N && byte_valid && byte_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_byte: got 0x%0h, expected none", byte_out);
      end else begin
        check("byte", int'(byte_out), int'(exp_q.pop_front()));
      end
      dec_len += int'(byte_out[6:0]) + 1;
      last_pop_cyc = cyc;
    end
  end

  task automatic start_frame();
    dec_len = 0;
    @(posedge HDMI_CLK); #1;
    start = 1'b1;
    @(posedge HDMI_CLK); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n);
    bit r;
    int wt;
    acc = 0;
    for (int i = 0; i < n; i++) begin
      pix_valid = 1'b1;
      pix_in    = fr[i];
      wt = 0;
      do begin
        @(negedge HDMI_CLK) r = pix_ready;
        @(posedge HDMI_CLK); #1;
        wt++;
      end while (!r && wt < 5000);
      if (!r) begin
        n_chk++;
        n_fail++;
        $display("FAIL pix_timeout: got ready=0 at pixel %0d, expected acceptance", i);
        break;
      end
      acc++;
    end
    pix_valid = 1'b0;
  endtask

  task automatic wait_done(input string name, input int nbytes);
    bit seen = 0;
    for (int k = 0; k < 5000 && !seen; k++) begin
      @(negedge HDMI_CLK);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_done_timeout: got no done, expected done", name);
      return;
    end
    check({name, "_done_lat"}, cyc - last_pop_cyc, 1);
    check({name, "_q_empty"}, exp_q.size(), 0);
    check({name, "_dec_len"}, dec_len, FRAME);
`ifdef RLE_BYTECOUNT_EN
    check({name, "_byte_count"}, int'(byte_count), nbytes);
`else
    check({name, "_byte_count"}, int'(byte_count), 0);
`endif
    @(negedge HDMI_CLK);
    check({name, "_busy_after"}, int'(busy), 0);
    check({name, "_done_pulse"}, int'(done), 0);
`ifdef RLE_BYTECOUNT_EN
    check({name, "_count_hold"}, int'(byte_count), nbytes);
`else
    check({name, "_count_hold"}, int'(byte_count), 0);
`endif
  endtask

  task automatic run_frame(input string name);
    int nb;
    nb = exp_q.size();
    start_frame();
    feed(FRAME);
    wait_done(name, nb);
  endtask

  task automatic model_frame();
    int cur, len, c;
    cur = int'(fr[0]);
    len = 1;
    for (int i = 1; i <= FRAME; i++) begin
      if (i < FRAME && int'(fr[i]) == cur) len++;
      else begin
        while (len > 0) begin
          c = (len > 128) ? 128 : len;
          exp_q.push_back({cur[0], 7'(c - 1)});
          len -= c;
        end
        if (i < FRAME) begin
          cur = int'(fr[i]);
          len = 1;
        end
      end
    end
  endtask

  initial begin
    int wt;
    // Reset state
    #12;
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_pix_ready", int'(pix_ready), 0);
    check("rst_byte_valid", int'(byte_valid), 0);
    check("rst_byte_out", int'(byte_out), 0);
    check("rst_byte_count", int'(byte_count), 0);
    @(posedge HDMI_CLK); #1;
    RESET_N = 1'b1;

    // All zeros: 128-cell wrap then a 2-cell tail
    rdy_mode = 1;
    fr = '0;
    exp_q.push_back(8'h7F); exp_q.push_back(8'h01);
    run_frame("zeros");

    // All ones
    fr = '1;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h81);
    run_frame("ones");

    // Single one, then 129 zeros: last pixel breaks a full run
    fr = '0; fr[0] = 1'b1;
    exp_q.push_back(8'h80); exp_q.push_back(8'h7F); exp_q.push_back(8'h00);
    run_frame("wrap_last");

    // 128 ones, 0, 1: last pixel breaks a value run (double push)
    fr = '1; fr[128] = 1'b0;
    exp_q.push_back(8'hFF); exp_q.push_back(8'h00); exp_q.push_back(8'h80);
    run_frame("brk_last");

    // Alternating with consumer stalled: pixel intake must stop at free < 2
    for (int i = 0; i < FRAME; i++) begin
      fr[i] = 1'(i % 2);
      exp_q.push_back((i % 2) ? 8'h80 : 8'h00);
    end
    rdy_mode = 0;
    start_frame();
    fork
      begin feeding = 1; feed(FRAME); feeding = 0; end
    join_none
    repeat (30) @(negedge HDMI_CLK);
    check("stall_pix_ready", int'(pix_ready), 0);
    check("stall_accepted", acc, 4);
    check("stall_head", int'(byte_out), 8'h00);
    rdy_mode = 1;
    wt = 0;
    while (feeding && wt < 20000) begin
      @(negedge HDMI_CLK);
      wt++;
    end
    if (feeding) begin
      n_chk++; n_fail++;
      $display("FAIL stall_feed_timeout: got feeding=1, expected 0");
    end
    wait_done("alt_stall", FRAME);

    // Reset mid-frame with two bytes held
    rdy_mode = 0;
    fr = '1; fr[3] = 1'b0;
    start_frame();
    feed(5);
    @(negedge HDMI_CLK);
    check("mid_head", int'(byte_out), 8'h82);
    check("mid_valid", int'(byte_valid), 1);
    @(posedge HDMI_CLK); #1;
    RESET_N = 1'b0;
    #1;
    check("mid_rst_valid", int'(byte_valid), 0);
    check("mid_rst_busy", int'(busy), 0);
    exp_q.delete();
    @(posedge HDMI_CLK); #1;
    RESET_N = 1'b1;
    rdy_mode = 1;
    fr = '0;
    exp_q.push_back(8'h7F); exp_q.push_back(8'h01);
    run_frame("post_rst");

    // Random frames with random consumer back-pressure
    rdy_mode = 2;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < FRAME; i++) fr[i] = (t == 2) ? 1'(($urandom_range(0, 15)) != 0) : 1'($urandom_range(0, 1));
      model_frame();
      run_frame("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
